// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, geometry and address field helpers for the data cache.
// Geometry: 64 lines x 4 words x 32 bits, byte address ADDR_W bits wide.
package dcache_pkg;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned OFFS_W  = 2;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned LINES   = 2 ** INDEX_W;
  localparam int unsigned WORDS   = 2 ** OFFS_W;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFS_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
    return a[OFFS_W+2 +: INDEX_W];
  endfunction

  function automatic logic [OFFS_W-1:0] get_offs(input logic [ADDR_W-1:0] a);
    return a[2 +: OFFS_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid bits, tag RAM and data RAM for the direct-mapped cache.
// Ports:
//   clk, rst              clock, async active-high reset (clears valid bits only)
//   index                 line index shared by lookup and all writes
//   rd_offs               word offset for the asynchronous read port
//   rd_valid/rd_tag/rd_word  lookup results for index/rd_offs
//   data_we/wr_offs/data_be/data_wdata  per-byte word write
//   tag_we/tag_wdata      tag write
//   valid_set/valid_clr   set or clear the valid bit of index (clear wins)
module dcache_array
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [OFFS_W-1:0]  rd_offs,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_word,
  input  logic               data_we,
  input  logic [OFFS_W-1:0]  wr_offs,
  input  logic [BE_W-1:0]    data_be,
  input  logic [DATA_W-1:0]  data_wdata,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   tag_wdata,
  input  logic               valid_set,
  input  logic               valid_clr
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];

  // Valid bit update; clearing takes priority so a miss always invalidates.
  always_comb begin
    valid_d = valid_q;
    if (valid_clr) begin
      valid_d[index] = 1'b0;
    end else if (valid_set) begin
      valid_d[index] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag RAM, not reset.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[index] <= tag_wdata;
    end
  end

  // Data RAM with byte-granular write, not reset.
  always_ff @(posedge clk) begin
    if (data_we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (data_be[b]) begin
          data_mem[{index, wr_offs}][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_word  = data_mem[{index, rd_offs}];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate MEM-stage data cache.
// Ports:
//   clk, rst            clock, async active-high reset
//   PStrobe/PByteEn     access valid; byte enables (0 = load, nonzero = store)
//   PAddr/PWData        byte address, store data
//   PRData/PReady       load data (held while PReady=0), access complete
//   MReq/MWrite/MAddr/MByteEn/MWData  memory request, held stable until MReady
//   MRData/MReady       memory read data and beat accept/return
//   stat_hits/stat_misses  read hit/miss counters
// Optional build macro DCACHE_STATS_EN enables the counters; otherwise they read 0.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              PStrobe,
  input  logic [BE_W-1:0]   PByteEn,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [DATA_W-1:0] PWData,
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              MReq,
  output logic              MWrite,
  output logic [ADDR_W-1:0] MAddr,
  output logic [BE_W-1:0]   MByteEn,
  output logic [DATA_W-1:0] MWData,
  input  logic [DATA_W-1:0] MRData,
  input  logic              MReady,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  state_e             state_q, state_d;
  logic [OFFS_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;

  logic [ADDR_W-1:0]  lk_addr_c;
  logic               hit_c;
  logic               load_hit_c;
  logic               refill_start_c;
  logic               pready_c;

  logic               arr_valid;
  logic [TAG_W-1:0]   arr_tag;
  logic [DATA_W-1:0]  arr_word;
  logic               data_we_c;
  logic [OFFS_W-1:0]  wr_offs_c;
  logic [BE_W-1:0]    data_be_c;
  logic [DATA_W-1:0]  data_wdata_c;
  logic               tag_we_c;
  logic               valid_set_c;
  logic               valid_clr_c;

  // Lookup the CPU address when idle, otherwise the latched transaction address.
  assign lk_addr_c      = (state_q == ST_IDLE) ? PAddr : addr_q;
  assign hit_c          = arr_valid && (arr_tag == get_tag(lk_addr_c));
  assign load_hit_c     = (state_q == ST_IDLE) && PStrobe && (PByteEn == '0) && hit_c;
  assign refill_start_c = (state_q == ST_IDLE) && PStrobe && (PByteEn == '0) && !hit_c;

  dcache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (get_index(lk_addr_c)),
    .rd_offs    (get_offs(lk_addr_c)),
    .rd_valid   (arr_valid),
    .rd_tag     (arr_tag),
    .rd_word    (arr_word),
    .data_we    (data_we_c),
    .wr_offs    (wr_offs_c),
    .data_be    (data_be_c),
    .data_wdata (data_wdata_c),
    .tag_we     (tag_we_c),
    .tag_wdata  (get_tag(lk_addr_c)),
    .valid_set  (valid_set_c),
    .valid_clr  (valid_clr_c)
  );

  // Next-state, array control and CPU handshake.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    prdata_d     = prdata_q;
    pready_c     = 1'b0;
    data_we_c    = 1'b0;
    wr_offs_c    = get_offs(lk_addr_c);
    data_be_c    = be_q;
    data_wdata_c = wdata_q;
    tag_we_c     = 1'b0;
    valid_set_c  = 1'b0;
    valid_clr_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_hit_c) begin
          pready_c = 1'b1;
          prdata_d = arr_word;
        end else if (refill_start_c) begin
          // Invalidate up front so an aborted refill never leaves a stale valid line.
          state_d     = ST_REFILL;
          beat_d      = '0;
          addr_d      = PAddr;
          valid_clr_c = 1'b1;
        end else if (PStrobe) begin
          state_d = ST_WRITE;
          addr_d  = PAddr;
          wdata_d = PWData;
          be_d    = PByteEn;
        end
      end

      ST_REFILL: begin
        if (MReady) begin
          data_we_c    = 1'b1;
          wr_offs_c    = beat_q;
          data_be_c    = '1;
          data_wdata_c = MRData;
          beat_d       = beat_q + OFFS_W'(1);
          if (beat_q == OFFS_W'(WORDS - 1)) begin
            tag_we_c    = 1'b1;
            valid_set_c = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        if (MReady) begin
          pready_c = 1'b1;
          // Write-through: update the cached copy only when it is present.
          if (hit_c) begin
            data_we_c = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      prdata_q <= prdata_d;
    end
  end

  // Memory side is a pure decode of registered state, so it is stable until MReady.
  assign MReq    = (state_q != ST_IDLE);
  assign MWrite  = (state_q == ST_WRITE);
  assign MAddr   = (state_q == ST_REFILL)
                   ? {addr_q[ADDR_W-1:OFFS_W+2], beat_q, 2'b00}
                   : {addr_q[ADDR_W-1:2], 2'b00};
  assign MByteEn = be_q;
  assign MWData  = wdata_q;

  assign PReady = pready_c;
  assign PRData = load_hit_c ? arr_word : prdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  // Hit/miss counters, wrapping at 2^32.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (load_hit_c) begin
      hits_d = hits_q + 32'd1;
    end
    if (refill_start_c) begin
      misses_d = misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl with a 2-cycle/beat memory model.
module tb_dcache_ctrl;

  localparam int LAT    = 2;
  localparam int BUDGET = 60;

  logic        clk;
  logic        rst;
  logic        PStrobe;
  logic [3:0]  PByteEn;
  logic [31:0] PAddr;
  logic [31:0] PWData;
  logic [31:0] PRData;
  logic        PReady;
  logic        MReq;
  logic        MWrite;
  logic [31:0] MAddr;
  logic [3:0]  MByteEn;
  logic [31:0] MWData;
  logic [31:0] MRData;
  logic        MReady;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  txn_t        log_q[$];
  int          mreq_cycles;
  logic [31:0] mem [logic [31:0]];

`ifdef DCACHE_STATS_EN
  localparam logic [31:0] STAT_ONE = 32'd1;
`else
  localparam logic [31:0] STAT_ONE = 32'd0;
`endif

  dcache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .PStrobe     (PStrobe),
    .PByteEn     (PByteEn),
    .PAddr       (PAddr),
    .PWData      (PWData),
    .PRData      (PRData),
    .PReady      (PReady),
    .MReq        (MReq),
    .MWrite      (MWrite),
    .MAddr       (MAddr),
    .MByteEn     (MByteEn),
    .MWData      (MWData),
    .MRData      (MRData),
    .MReady      (MReady),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Untouched memory word at byte address a reads as C0DE_<a[15:0]>.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    if (mem.exists(a)) w = mem[a];
    else w = {16'hC0DE, a[15:0]};
    return w;
  endfunction

  // Memory responder: each beat accepted on the LAT-th cycle MReq is seen.
  initial begin
    int cnt;
    logic [31:0] w;
    cnt = 0;
    MReady = 1'b0;
    MRData = '0;
    mreq_cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        MReady = 1'b0;
        cnt = 0;
      end else begin
        if (MReady) begin
          MReady = 1'b0;
          cnt = 0;
        end
        if (MReq) begin
          mreq_cycles++;
          cnt++;
          if (cnt == LAT) begin
            MReady = 1'b1;
            log_q.push_back('{wr: MWrite, addr: MAddr, be: MByteEn, wd: MWData});
            if (MWrite) begin
              w = mem_rd(MAddr);
              for (int b = 0; b < 4; b++) if (MByteEn[b]) w[8*b +: 8] = MWData[8*b +: 8];
              mem[MAddr] = w;
            end else begin
              MRData = mem_rd(MAddr);
            end
          end
        end
      end
    end
  end

  // One CPU access held until PReady; cyc counts cycles including the completing one.
  task automatic access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    bit done;
    done = 1'b0;
    rd = 'x;
    @(posedge clk);
    #2;
    PStrobe = 1'b1;
    PAddr = a;
    PByteEn = be;
    PWData = wd;
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (PReady === 1'b1) begin
        done = 1'b1;
        rd = PRData;
      end
    end
    checks++;
    if (!done) $display("FAIL access_timeout addr=%h got no PReady within %0d cycles", a, BUDGET);
    else passed++;
    @(posedge clk);
    #2;
    PStrobe = 1'b0;
    PByteEn = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    PStrobe = 1'b1;
    PByteEn = '0;
    PAddr = 32'h100;
    PWData = '0;
    repeat (2) @(negedge clk);
    checks++; if (MReq !== 1'b0) $display("FAIL reset_mreq got %b want 0", MReq); else passed++;
    checks++; if (MWrite !== 1'b0) $display("FAIL reset_mwrite got %b want 0", MWrite); else passed++;
    checks++; if (PReady !== 1'b0) $display("FAIL reset_pready got %b want 0", PReady); else passed++;
    checks++; if (PRData !== 32'h0) $display("FAIL reset_prdata got %h want 0", PRData); else passed++;
    checks++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0)
      $display("FAIL reset_stats got %0d/%0d want 0/0", stat_hits, stat_misses); else passed++;
    PStrobe = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (PReady !== 1'b0) $display("FAIL idle_no_strobe_pready got %b want 0", PReady); else passed++;
  endtask

  task automatic test_cold_load();
    logic [31:0] rd;
    int cyc;
    log_q.delete();
    access(32'h100, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 10) $display("FAIL cold_latency got %0d want 10", cyc); else passed++;
    checks++; if (rd !== 32'hC0DE0100) $display("FAIL cold_data got %h want c0de0100", rd); else passed++;
    checks++; if (log_q.size() !== 4) $display("FAIL cold_beats got %0d want 4", log_q.size()); else passed++;
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].wr !== 1'b0 || log_q[i].addr !== 32'h100 + 32'(4 * i))
        $display("FAIL cold_beat%0d got wr=%b addr=%h want wr=0 addr=%h",
                 i, log_q[i].wr, log_q[i].addr, 32'h100 + 32'(4 * i));
      else passed++;
    end
    checks++; if (stat_misses !== STAT_ONE) $display("FAIL cold_misses got %0d want %0d", stat_misses, STAT_ONE); else passed++;
  endtask

  task automatic test_load_hit();
    logic [31:0] rd;
    logic [31:0] h0;
    int cyc;
    h0 = stat_hits;
    mreq_cycles = 0;
    access(32'h108, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 1) $display("FAIL hit_latency got %0d want 1", cyc); else passed++;
    checks++; if (rd !== 32'hC0DE0108) $display("FAIL hit_data got %h want c0de0108", rd); else passed++;
    checks++; if (mreq_cycles !== 0) $display("FAIL hit_no_mreq got %0d want 0", mreq_cycles); else passed++;
    checks++; if (stat_hits - h0 !== STAT_ONE)
      $display("FAIL hit_count_delta got %0d want %0d", stat_hits - h0, STAT_ONE); else passed++;
  endtask

  task automatic test_store_hit();
    logic [31:0] rd;
    int cyc;
    log_q.delete();
    access(32'h104, 4'b0011, 32'hAABBCCDD, rd, cyc);
    checks++; if (cyc !== 3) $display("FAIL store_latency got %0d want 3", cyc); else passed++;
    checks++; if (log_q.size() !== 1) $display("FAIL store_txns got %0d want 1", log_q.size()); else passed++;
    if (log_q.size() > 0) begin
      checks++;
      if (log_q[0].wr !== 1'b1 || log_q[0].addr !== 32'h104 || log_q[0].be !== 4'b0011 || log_q[0].wd !== 32'hAABBCCDD)
        $display("FAIL store_txn got wr=%b addr=%h be=%b wd=%h want 1/104/0011/aabbccdd",
                 log_q[0].wr, log_q[0].addr, log_q[0].be, log_q[0].wd);
      else passed++;
    end
    checks++; if (PRData !== 32'hC0DE0108) $display("FAIL prdata_hold got %h want c0de0108", PRData); else passed++;
    log_q.delete();
    access(32'h104, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 1) $display("FAIL merged_hit_latency got %0d want 1", cyc); else passed++;
    checks++; if (rd !== 32'hC0DECCDD) $display("FAIL merged_data got %h want c0deccdd", rd); else passed++;
  endtask

  task automatic test_store_miss();
    logic [31:0] rd;
    int cyc;
    log_q.delete();
    access(32'h2000, 4'hF, 32'h11223344, rd, cyc);
    checks++; if (cyc !== 3 || log_q.size() !== 1)
      $display("FAIL store_miss got cyc=%0d txns=%0d want 3/1", cyc, log_q.size()); else passed++;
    log_q.delete();
    access(32'h2000, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 10) $display("FAIL no_allocate_latency got %0d want 10", cyc); else passed++;
    checks++; if (rd !== 32'h11223344) $display("FAIL store_miss_data got %h want 11223344", rd); else passed++;
  endtask

  task automatic test_conflict();
    logic [31:0] rd;
    int cyc;
    access(32'h100, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 1 || rd !== 32'hC0DE0100)
      $display("FAIL conflict_pre got cyc=%0d data=%h want 1/c0de0100", cyc, rd); else passed++;
    log_q.delete();
    access(32'h500, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 10 || rd !== 32'hC0DE0500)
      $display("FAIL conflict_evict got cyc=%0d data=%h want 10/c0de0500", cyc, rd); else passed++;
    if (log_q.size() > 0) begin
      checks++; if (log_q[0].addr !== 32'h500) $display("FAIL conflict_beat0 got %h want 500", log_q[0].addr); else passed++;
    end
    access(32'h100, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 10 || rd !== 32'hC0DE0100)
      $display("FAIL conflict_reload got cyc=%0d data=%h want 10/c0de0100", cyc, rd); else passed++;
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd;
    int cyc;
    int n;
    log_q.delete();
    @(posedge clk);
    #2;
    PStrobe = 1'b1;
    PAddr = 32'h300;
    PByteEn = '0;
    n = 0;
    while (log_q.size() < 2 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++; if (log_q.size() < 2) $display("FAIL midreset_wait got %0d beats want 2", log_q.size()); else passed++;
    @(posedge clk);
    @(negedge clk);
    checks++; if (MReq !== 1'b1 || MAddr !== 32'h308)
      $display("FAIL midreset_beat2 got mreq=%b addr=%h want 1/308", MReq, MAddr); else passed++;
    rst = 1'b1;
    PStrobe = 1'b0;
    #1;
    checks++; if (MReq !== 1'b0) $display("FAIL midreset_mreq got %b want 0", MReq); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0)
      $display("FAIL midreset_stats got %0d/%0d want 0/0", stat_hits, stat_misses); else passed++;
    access(32'h300, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 10 || rd !== 32'hC0DE0300)
      $display("FAIL partial_line_miss got cyc=%0d data=%h want 10/c0de0300", cyc, rd); else passed++;
    access(32'h104, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 10 || rd !== 32'hC0DECCDD)
      $display("FAIL post_reset_invalid got cyc=%0d data=%h want 10/c0deccdd", cyc, rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache that sits in the MEM stage, between the pipeline controller and main memory.
- CPU side: consumes PStrobe and the MEM-stage byte enables; returns PReady, which the controller uses to build stall_cache.
- Memory side: single-word request/ready handshake, with burst refill driven by a beat counter.
- Read hits complete in zero wait cycles; misses and all stores stall the pipeline.

Parameters:
INDEX_W, 6, line index width (64 lines)
OFFS_W, 2, word-offset width (4 words per line)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  reset
PStrobe  in  1  MEM-stage access valid (load or store)
PByteEn  in  4  store byte enables; 0 = load, nonzero = store
PAddr  in  ADDR_W  byte address; bits [1:0] ignored
PWData  in  32  store data
PRData  out  32  load data, valid when PReady=1
PReady  out  1  access complete this cycle
MReq  out  1  memory request
MWrite  out  1  1 = write, 0 = read
MAddr  out  ADDR_W  word-aligned memory address
MByteEn  out  4  write byte enables
MWData  out  32  write data
MRData  in  32  read data, valid with MReady
MReady  in  1  memory accepts/returns the current beat
stat_hits  out  32  read-hit counter (see Optional Feature)
stat_misses  out  32  read-miss counter (see Optional Feature)

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - All valid bits cleared; state IDLE; beat counter 0.
  - MReq=0, MWrite=0, PReady=0, PRData=0, stat counters 0.
  - Tag/data arrays are not reset.
- Address split:
  - word offset = PAddr[OFFS_W+1:2]
  - index = next INDEX_W bits
  - tag = remaining upper bits
  - hit = valid[index] & (tag_array[index]==tag)
- States: IDLE, REFILL, WRITE.
- IDLE:
  - PStrobe=0 -> PReady=0.
  - Load hit -> PReady=1 combinationally in the same cycle; PRData = selected word.
  - Load miss -> PReady=0; go to REFILL with beat=0; invalidate the line immediately.
  - Store -> PReady=0; go to WRITE, latching address, data and byte enables.
- REFILL:
  - MReq=1, MWrite=0, MAddr={tag,index,beat,2'b00}; beats issued in ascending order 0..3.
  - On each MReady: write MRData into data[index][beat]; beat++.
  - On the MReady of the last beat: write tag, set valid, go to IDLE.
  - The still-stalled load then hits the following cycle, so miss latency = sum of beat latencies + 1.
- WRITE:
  - MReq=1, MWrite=1; MAddr/MWData/MByteEn come from the latched values.
  - On MReady: PReady=1 in that cycle; go to IDLE.
  - If the latched address hits, merge the enabled bytes into the cached word in the same cycle.
  - A store miss does not allocate.
- Handshake: once MReq rises, MReq, MAddr, MWData and MByteEn stay stable until the MReady cycle. MReq is deasserted for at least the cycle after each completed transaction in WRITE; REFILL beats may be back-to-back.
- PStrobe deasserting mid-REFILL/WRITE: the transaction still completes and PReady pulses are ignored. New requests are sampled only in IDLE.
- Reset mid-operation: abort immediately, MReq=0, all lines invalid; a partial refill never becomes valid.
- Index conflict: a refill overwrites the line; no writeback, since the cache is write-through.
- PRData holds its last value when PReady=0.

Optional Feature:
DCACHE_STATS_EN
- Defined: stat_hits increments on each IDLE load hit with PReady=1. stat_misses increments on each IDLE->REFILL transition. Both are 32-bit and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter registers are synthesized.

Decomposition:
- dcache_pkg holds:
  - state enum {IDLE, REFILL, WRITE}
  - localparams LINES=2**INDEX_W, WORDS=2**OFFS_W, TAG_W=ADDR_W-INDEX_W-OFFS_W-2
  - field-extraction functions for tag/index/offset
- Sub-module dcache_array: valid bits, tag RAM, and data RAM with per-byte word write and an asynchronous read port. valid is reset by rst, with set/clear inputs.

Test Plan:
1. Cold load 0x100, memory latency 2 cycles/beat -> four MReq reads to 0x100,0x104,0x108,0x10C; PReady=0 throughout; PReady=1 one cycle after the 4th MReady with PRData=mem[0x100].
2. Load 0x108 immediately after test 1 -> same-cycle hit, no MReq, PRData=mem[0x108]; stat_hits=1 (with DCACHE_STATS_EN).
3. Store 0xAABBCCDD, PByteEn=4'b0011 to 0x104 (hit) -> one MReq write with MByteEn=0011; then load 0x104 returns {old[31:16],16'hCCDD}.
4. Store to 0x2000 (miss) -> memory write only; subsequent load 0x2000 takes the miss/refill path.
5. Load 0x100 then 0x100+(64*16) (same index, different tag) -> second access refills and evicts; reload of 0x100 misses again.
6. Assert rst during beat 2 of a refill -> MReq=0 immediately; the line is invalid after reset and the next load to it misses.
